// File: rtl/sys_array_pkg.sv
// Shared definitions for the systolic-array feeder and its companions.
package sys_array_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWload,
        StGap,
        StFeed,
        StDrain,
        StDone
    } feeder_state_t;

    // Number of skewed feed steps for an a_w x a_l data matrix.
    function automatic int unsigned feed_steps(input int unsigned a_w, input int unsigned a_l);
        return a_w + a_l - 1;
    endfunction

endpackage

// File: rtl/sys_array_skew_mux.sv
// Combinational diagonal-skew selector: lane j carries matrix[step-j][j] or zero.
module sys_array_skew_mux #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned A_W        = 5,
    parameter int unsigned A_L        = 3,
    parameter int unsigned CNT_W      = 3
) (
    input  logic [0:A_W-1][0:A_L-1][DATA_WIDTH-1:0] matrix,
    input  logic [CNT_W-1:0]                        step,
    output logic [0:A_L-1][DATA_WIDTH-1:0]          lanes
);

    always_comb begin
        lanes = '0;
        for (int j = 0; j < int'(A_L); j++) begin
            for (int i = 0; i < int'(A_W); i++) begin
                if (int'(step) == i + j) begin
                    lanes[j] = matrix[i][j];
                end
            end
        end
    end

endmodule

// File: rtl/sys_array_feeder.sv
// Job sequencer for sys_array_basic: weight load pulse, gap, skewed feed, drain, done.
module sys_array_feeder
    import sys_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned ARRAY_A_W    = 5,
    parameter int unsigned ARRAY_A_L    = 3,
    parameter int unsigned ARRAY_W_W    = 3,
    parameter int unsigned ARRAY_W_L    = 4,
    parameter int unsigned DRAIN_CYCLES = 12
) (
    input  logic                                               clk,
    input  logic                                               reset_n,
    input  logic                                               start,
    input  logic                                               abort,
    input  logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0] matrix_in,
    input  logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0] weight_in,
    output logic                                               weights_load,
    output logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0] weight_data,
    output logic [0:ARRAY_A_L-1][DATA_WIDTH-1:0]               input_data,
    output logic                                               busy,
    output logic                                               done
);

    localparam int unsigned S          = feed_steps(ARRAY_A_W, ARRAY_A_L);
    localparam int unsigned CNT_MAX    = (S > DRAIN_CYCLES) ? S : DRAIN_CYCLES;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(S - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    feeder_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic accept;
    logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0] mat_q;
    logic [0:ARRAY_A_L-1][DATA_WIDTH-1:0] lanes_mux;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            // DONE behaves like IDLE for start so back-to-back jobs need only the DONE cycle.
            StIdle, StDone: begin
                state_d = StIdle;
                if (start && !abort) begin
                    accept  = 1'b1;
                    state_d = StWload;
                end
            end
            StWload: state_d = StGap;
            StGap: begin
                state_d = StFeed;
                cnt_d   = '0;
            end
            StFeed: begin
                if (cnt_q == FEED_LAST) begin
                    cnt_d   = '0;
                    state_d = (DRAIN_CYCLES == 0) ? StDone : StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    // The mux looks at the next step so the registered lanes line up with the FEED state.
    sys_array_skew_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .A_W       (ARRAY_A_W),
        .A_L       (ARRAY_A_L),
        .CNT_W     (CNT_W)
    ) u_skew_mux (
        .matrix(mat_q),
        .step  (cnt_d),
        .lanes (lanes_mux)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            mat_q        <= '0;
            weight_data  <= '0;
            weights_load <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            input_data   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            weights_load <= (state_d == StWload);
            busy         <= (state_d inside {StWload, StGap, StFeed, StDrain});
            done         <= (state_d == StDone);
            input_data   <= (state_d == StFeed) ? lanes_mux : '0;
            if (accept) begin
                mat_q       <= matrix_in;
                weight_data <= weight_in;
            end
        end
    end

endmodule

// File: tb/tb_sys_array_feeder.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, monitors pop and compare.
module tb_sys_array_feeder;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         wl;
        logic [47:0]  lanes;
        logic [191:0] wd;
    } rec_t;

    logic clk, reset_n, abort;
    logic start_a, start_b, start_c;
    logic [0:4][0:2][15:0] matrix_in;
    logic [0:2][0:3][15:0] weight_in;
    logic [0:0][0:0][15:0] matrix_c;

    logic wl_a, busy_a, done_a, wl_b, busy_b, done_b, wl_c, busy_c, done_c;
    logic [0:2][0:3][15:0] wd_a, wd_b, wd_c;
    logic [0:2][15:0] lanes_a, lanes_b;
    logic [0:0][15:0] lanes_c;

    int checks = 0;
    int errors = 0;
    rec_t q_a[$], q_b[$], q_c[$];

    logic [47:0] nom_tab [7];
    logic [47:0] neg_tab [7];
    logic [47:0] c_tab [7];
    logic [0:4][0:2][15:0] nom_m, neg_m, alt_m;
    logic [0:2][0:3][15:0] nom_w, alt_w;

    sys_array_feeder dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort),
        .matrix_in(matrix_in), .weight_in(weight_in), .weights_load(wl_a),
        .weight_data(wd_a), .input_data(lanes_a), .busy(busy_a), .done(done_a)
    );

    sys_array_feeder #(.DRAIN_CYCLES(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(1'b0),
        .matrix_in(matrix_in), .weight_in(weight_in), .weights_load(wl_b),
        .weight_data(wd_b), .input_data(lanes_b), .busy(busy_b), .done(done_b)
    );

    sys_array_feeder #(.ARRAY_A_W(1), .ARRAY_A_L(1), .DRAIN_CYCLES(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_c), .abort(1'b0),
        .matrix_in(matrix_c), .weight_in(weight_in), .weights_load(wl_c),
        .weight_data(wd_c), .input_data(lanes_c), .busy(busy_c), .done(done_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs after edge e of a job with s feed steps and d drain cycles.
    function automatic rec_t exp_at(input int e, input int s, input int d,
                                    input logic [47:0] tab [7], input logic [191:0] w);
        rec_t r;
        r    = '0;
        r.wd = w;
        if (e == 2 + s + d) begin
            r.done = 1'b1;
        end else begin
            r.busy = 1'b1;
            if (e == 0) r.wl = 1'b1;
            else if (e >= 2 && e < 2 + s) r.lanes = tab[e-2];
        end
        return r;
    endfunction

    task automatic cmp(input string name, input rec_t exp, input rec_t act);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b wl=%b lanes=%h wd=%h, expected busy=%b done=%b wl=%b lanes=%h wd=%h",
                     name, act.busy, act.done, act.wl, act.lanes, act.wd,
                     exp.busy, exp.done, exp.wl, exp.lanes, exp.wd);
        end
    endtask

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic b, input logic d);
        checks++;
        errors++;
        $display("FAIL %s: busy=%b done=%b with no expected output queued", name, b, d);
    endtask

    always @(negedge clk) begin
        rec_t act;
        act = '{busy_a, done_a, wl_a, lanes_a, wd_a};
        if (busy_a || done_a) begin
            if (q_a.size() == 0) unexpected("main_unexpected", busy_a, done_a);
            else cmp("main_seq", q_a.pop_front(), act);
        end else begin
            chk("main_idle", {143'd0, wl_a, lanes_a}, '0);
        end
    end

    always @(negedge clk) begin
        rec_t act;
        act = '{busy_b, done_b, wl_b, lanes_b, wd_b};
        if (busy_b || done_b) begin
            if (q_b.size() == 0) unexpected("b2b_unexpected", busy_b, done_b);
            else cmp("b2b_seq", q_b.pop_front(), act);
        end
    end

    always @(negedge clk) begin
        rec_t act;
        act = '{busy_c, done_c, wl_c, {32'd0, lanes_c}, wd_c};
        if (busy_c || done_c) begin
            if (q_c.size() == 0) unexpected("one_lane_unexpected", busy_c, done_c);
            else cmp("one_lane_seq", q_c.pop_front(), act);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nom_tab[0] = {16'd1,  16'd0,  16'd0};
        nom_tab[1] = {16'd4,  16'd2,  16'd0};
        nom_tab[2] = {16'd7,  16'd5,  16'd3};
        nom_tab[3] = {16'd10, 16'd8,  16'd6};
        nom_tab[4] = {16'd13, 16'd11, 16'd9};
        nom_tab[5] = {16'd0,  16'd14, 16'd12};
        nom_tab[6] = {16'd0,  16'd0,  16'd15};
        for (int i = 0; i < 7; i++) begin
            neg_tab[i] = {-nom_tab[i][47:32], -nom_tab[i][31:16], -nom_tab[i][15:0]};
            c_tab[i]   = '0;
        end
        c_tab[0] = {32'd0, 16'h8001};
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 3; j++) begin
                nom_m[i][j] = 16'(3 * i + j + 1);
                neg_m[i][j] = -nom_m[i][j];
                alt_m[i][j] = 16'(100 + 3 * i + j);
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) begin
                nom_w[i][j] = 16'(4 * i + j + 1);
                alt_w[i][j] = 16'(200 + 4 * i + j);
            end
        end

        reset_n = 1'b1; abort = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        matrix_in = nom_m; weight_in = nom_w; matrix_c = '0;
        #2 reset_n = 1'b0;
        start_a = 1'b1;
        repeat (4) tick();
        chk("reset_outs", {188'd0, busy_a, done_a, wl_a, |lanes_a}, '0);
        chk("reset_wd", wd_a, '0);
        start_a = 1'b0;
        reset_n = 1'b1;
        repeat (2) tick();
        chk("start_in_reset_ignored", {wd_a, busy_a}, '0);

        // Nominal job, plus a second start at edge 5 that must be ignored.
        for (int e = 0; e < 22; e++) q_a.push_back(exp_at(e, 7, 12, nom_tab, nom_w));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("wd_2_3", {176'd0, wd_a[2][3]}, 192'd12);
        repeat (4) tick();
        start_a = 1'b1; matrix_in = alt_m; weight_in = alt_w;
        tick();
        start_a = 1'b0;
        repeat (19) tick();

        // abort and start together in IDLE: nothing captured.
        abort = 1'b1; start_a = 1'b1;
        tick();
        abort = 1'b0; start_a = 1'b0;
        tick();
        chk("abort_wins_idle", {wd_a, busy_a}, {nom_w, 1'b0});

        // Abort at edge 6, weights retained, restart at edge 8.
        matrix_in = nom_m; weight_in = alt_w;
        for (int e = 0; e < 6; e++) q_a.push_back(exp_at(e, 7, 12, nom_tab, alt_w));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_outs", {wd_a, busy_a, |lanes_a}, {alt_w, 2'b00});
        tick();
        matrix_in = neg_m; weight_in = nom_w;
        for (int e = 0; e < 22; e++) q_a.push_back(exp_at(e, 7, 12, neg_tab, nom_w));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (23) tick();

        // Asynchronous reset between edges 4 and 5.
        matrix_in = nom_m; weight_in = nom_w;
        for (int e = 0; e < 5; e++) q_a.push_back(exp_at(e, 7, 12, nom_tab, nom_w));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        #6 reset_n = 1'b0;
        #1;
        chk("async_rst_outs", {188'd0, busy_a, done_a, wl_a, |lanes_a}, '0);
        chk("async_rst_wd", wd_a, '0);
        tick();
        reset_n = 1'b1;
        repeat (25) tick();

        // Back-to-back with no drain: three jobs of 10 cycles.
        for (int k = 0; k < 3; k++)
            for (int e = 0; e < 10; e++) q_b.push_back(exp_at(e, 7, 0, nom_tab, nom_w));
        start_b = 1'b1;
        tick();
        repeat (29) tick();
        start_b = 1'b0;
        repeat (3) tick();

        // Single-lane array: S = 1, jobs of 4 cycles.
        matrix_c = 16'h8001;
        for (int k = 0; k < 3; k++)
            for (int e = 0; e < 4; e++) q_c.push_back(exp_at(e, 1, 0, c_tab, nom_w));
        start_c = 1'b1;
        tick();
        repeat (11) tick();
        start_c = 1'b0;
        repeat (3) tick();

        chk("main_queue_drained", 192'(q_a.size()), '0);
        chk("b2b_queue_drained", 192'(q_b.size()), '0);
        chk("one_lane_queue_drained", 192'(q_c.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sys_array_feeder.md
# sys_array_feeder

Upstream sequencer for `sys_array_basic`. It captures a data matrix and a weight matrix in one start handshake, then drives the array in order: a one-cycle `weights_load` pulse, one idle cycle, the diagonally skewed input wavefront, and a zero-filled drain period. It ends each job with a `done` pulse. This replaces hand-written skew sequences in benches and higher-level controllers.

## Interface
- `DATA_WIDTH`, 16, element width (signed)
- `ARRAY_A_W`, 5, data matrix rows (vectors streamed)
- `ARRAY_A_L`, 3, data matrix columns = output lanes
- `ARRAY_W_W`, 3, weight matrix rows
- `ARRAY_W_L`, 4, weight matrix columns
- `DRAIN_CYCLES`, 12, zero cycles after last feed step before `done`
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  job request, sampled only in IDLE
- `abort`  in  1  synchronous job cancel
- `matrix_in`  in  [0:ARRAY_A_W-1][0:ARRAY_A_L-1] x DATA_WIDTH  data matrix, captured on accepted start
- `weight_in`  in  [0:ARRAY_W_W-1][0:ARRAY_W_L-1] x DATA_WIDTH  weights, captured on accepted start
- `weights_load`  out  1  pulse to array
- `weight_data`  out  [0:ARRAY_W_W-1][0:ARRAY_W_L-1] x DATA_WIDTH  captured weights, held stable
- `input_data`  out  [0:ARRAY_A_L-1] x DATA_WIDTH  skewed lane vector to array
- `busy`  out  1  high from accepted start until `done`/abort
- `done`  out  1  one-cycle completion pulse

## Operation
- Decided: one clock `clk`; reset `reset_n` asynchronous, active-low.
- FSM states: IDLE, WLOAD, GAP, FEED, DRAIN, DONE.
- IDLE + `start` and no `abort`: capture both matrices, go to WLOAD.
- WLOAD lasts 1 cycle, then GAP.
- GAP lasts 1 cycle, then FEED.
- FEED lasts S = ARRAY_A_W+ARRAY_A_L-1 cycles, step counter t = 0..S-1.
- Then DRAIN for DRAIN_CYCLES cycles. If DRAIN_CYCLES = 0, DRAIN is skipped.
- DONE lasts 1 cycle, then IDLE.
- Skew rule at FEED step t: lane j = matrix[t-j][j] when 0 ≤ t-j < ARRAY_A_W, else 0. Outside FEED, all lanes = 0.
- No arithmetic on data: values pass bit-exact and signed. The counter is sized to $clog2(max(S, DRAIN_CYCLES)+1).
- `start` outside IDLE is ignored; there is no queueing.
- `abort` in any non-IDLE state: next edge goes to IDLE, zeros all lanes, drops `weights_load`/`busy`, and suppresses `done`. Captured weights are retained.
- `abort` and `start` both high in IDLE: abort wins, nothing is captured.
- Reset mid-job: immediate return to IDLE with all outputs at their reset values.

## Timing
- All outputs are registered.
- Reset values: `weights_load`=0, `busy`=0, `done`=0, all `input_data` lanes 0, all `weight_data` 0.
- Edge numbering: edge 0 is the edge that samples an accepted `start`.
  - After edge 0: `busy`=1, `weights_load`=1, `weight_data` = captured weights.
  - After edge 1: `weights_load`=0, lanes 0 (GAP).
  - After edge 2+t, t = 0..S-1: feed step t on lanes.
  - After edge 2+S .. 1+S+DRAIN_CYCLES: lanes 0.
  - After edge 2+S+DRAIN_CYCLES: `done`=1, `busy`=0.
  - Earliest next `start` is sampled on that same edge+1. Back-to-back jobs are separated by exactly one DONE cycle.
- With defaults: S = 7, `done` is visible after edge 21, and a job occupies 22 cycles.

## Structure
- Shared package `sys_array_pkg` holds:
  - the FSM state enum typedef `feeder_state_t`;
  - the helper function `feed_steps(a_w, a_l)` returning S;
  - a `DATA_WIDTH` default constant shared with `sys_array_basic`.
- One sub-module, `sys_array_skew_mux`: combinational, takes the captured matrix and t, and outputs the lane vector per the skew rule. The FSM/counter stays in `sys_array_feeder`, which registers the mux output.

## Test plan
- Reset and idle:
  - Stimulus: hold `reset_n`=0 for 4 cycles.
  - Response: all outputs 0.
  - Also: `start` while `reset_n`=0 is ignored.
- Nominal job:
  - Stimulus: matrix rows {1,2,3},{4,5,6},{7,8,9},{A,B,C},{D,E,F}; weights 1..12; pulse `start`.
  - Response: `weights_load` high exactly after edge 0, and `weight_data[2][3]`=12.
  - Lanes after edge 2 = {1,0,0}; after edge 5 = {A,8,6}; after edge 7 = {0,E,C}; after edge 8 = {0,0,F}.
  - Lanes are 0 from edge 9 on; `done` after edge 21.
- `start` during busy:
  - Stimulus: a second `start` at edge 5 with different data.
  - Response: the job is unaffected and the lane values are unchanged.
- Abort:
  - Stimulus: `abort` at edge 6.
  - Response: after edge 6 `busy`=0, lanes 0, no `done` ever.
  - A new `start` at edge 8 runs a full, correct job.
- Async reset mid-FEED:
  - Stimulus: assert `reset_n`=0 between edges 4 and 5.
  - Response: outputs clear immediately (before the next edge) and there is no `done`.
- Back-to-back and parameter sweep:
  - Stimulus: `start` held high continuously with `DRAIN_CYCLES`=0.
  - Response: jobs of 2+S+1 cycles with a single `done` each.
  - Repeat with ARRAY_A_W=1, ARRAY_A_L=1: S=1, and the single lane equals matrix[0][0] after edge 2.
